// File: rtl/sva_window_monitor_if.sv
// Bundles the stimulus and result signals of the bounded-response monitor.
// The master side drives trig/resp/dis/clr; the slave side is the monitor.
interface sva_window_monitor_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic                 dis_i;
    logic                 clr_i;
    logic [NCH-1:0]       trig_i;
    logic [NCH-1:0]       resp_i;
    logic [NCH-1:0]       pass_o;
    logic [NCH-1:0]       fail_o;
    logic [NCH-1:0]       fail_sticky_o;
    logic [NCH*CNT_W-1:0] fail_cnt_o;
    logic [NCH-1:0]       pending_o;

    modport master (
        output dis_i, clr_i, trig_i, resp_i,
        input  pass_o, fail_o, fail_sticky_o, fail_cnt_o, pending_o
    );

    modport slave (
        input  dis_i, clr_i, trig_i, resp_i,
        output pass_o, fail_o, fail_sticky_o, fail_cnt_o, pending_o
    );
endinterface

// File: rtl/sva_window_monitor.sv
// Hardware checker for "trig |-> ##[MIN_DLY:MAX_DLY] resp" with disable-iff,
// one age shift register per channel, registered pass/fail pulses and counters.
module sva_window_monitor #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    sva_window_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [MAX_DLY:0] window_mask();
        logic [MAX_DLY:0] m;
        m = '0;
        for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
            m[k] = 1'b1;
        end
        return m;
    endfunction

    // Ages that a response is allowed to discharge.
    localparam logic [MAX_DLY:0] WIN = window_mask();

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [MAX_DLY:1] pend_q;
        logic [MAX_DLY:1] pend_d;
        logic [MAX_DLY:0] live;
        logic [MAX_DLY:0] disch;
        logic             pass_ev;
        logic             fail_ev;
        logic             pass_q;
        logic             fail_q;
        logic             pending_q;
        logic             sticky_q;
        logic [CNT_W-1:0] cnt_q;

        // Bit 0 of live is this cycle's new attempt; higher bits are in flight.
        always_comb begin
            live    = {pend_q, bus.trig_i[ch] & ~bus.dis_i};
            disch   = live & WIN & {(MAX_DLY+1){bus.resp_i[ch]}};
            pass_ev = (|disch) & ~bus.dis_i;
            fail_ev = live[MAX_DLY] & ~bus.resp_i[ch] & ~bus.dis_i;
            pend_d  = '0;
            if (!bus.dis_i) begin
                pend_d = live[MAX_DLY-1:0] & ~disch[MAX_DLY-1:0];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_q    <= '0;
                pass_q    <= 1'b0;
                fail_q    <= 1'b0;
                pending_q <= 1'b0;
                sticky_q  <= 1'b0;
                cnt_q     <= '0;
            end else begin
                pend_q    <= pend_d;
                pass_q    <= pass_ev;
                fail_q    <= fail_ev;
                pending_q <= |pend_d;
                // Clear beats a coincident expiry; the fail pulse still fires.
                if (bus.clr_i) begin
                    sticky_q <= 1'b0;
                    cnt_q    <= '0;
                end else if (fail_ev) begin
                    sticky_q <= 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end

        assign bus.pass_o[ch]                     = pass_q;
        assign bus.fail_o[ch]                     = fail_q;
        assign bus.pending_o[ch]                  = pending_q;
        assign bus.fail_sticky_o[ch]              = sticky_q;
        assign bus.fail_cnt_o[ch*CNT_W +: CNT_W]  = cnt_q;
    end

endmodule

// File: tb/tb_sva_window_monitor.sv
// Bench for sva_window_monitor: hand-computed vector table, an attempt-list
// reference model under random stimulus, and counter/reset corner sequences.
module tb_sva_window_monitor;

    localparam int NCH   = 2;
    localparam int MAXD  = 3;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sva_window_monitor_if #(.NCH(NCH), .CNT_W(CNT_W)) bus0 ();
    sva_window_monitor_if #(.NCH(NCH), .CNT_W(CNT_W)) bus1 ();

    assign bus1.dis_i  = bus0.dis_i;
    assign bus1.clr_i  = bus0.clr_i;
    assign bus1.trig_i = bus0.trig_i;
    assign bus1.resp_i = bus0.resp_i;

    sva_window_monitor #(.NCH(NCH), .MIN_DLY(1), .MAX_DLY(MAXD), .CNT_W(CNT_W))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sva_window_monitor #(.NCH(NCH), .MIN_DLY(0), .MAX_DLY(MAXD), .CNT_W(CNT_W))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: list of attempt ages per (model, channel).
    int         att[4][$];
    logic [1:0] e_pass[2];
    logic [1:0] e_fail[2];
    logic [1:0] e_pend[2];
    logic [1:0] e_sticky[2];
    logic [3:0] e_cnt[2][2];

    typedef struct {
        logic [1:0] trig;
        logic [1:0] resp;
        logic       dis;
        logic       clr;
        logic [1:0] pass;
        logic [1:0] fail;
        logic [1:0] pend;
        logic [1:0] sticky;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) att[i].delete();
        for (int m = 0; m < 2; m++) begin
            e_pass[m] = '0; e_fail[m] = '0; e_pend[m] = '0; e_sticky[m] = '0;
            e_cnt[m][0] = '0; e_cnt[m][1] = '0;
        end
    endtask

    task automatic model_step(input int m, input int mn, input logic [1:0] t,
                              input logic [1:0] r, input logic d, input logic c);
        for (int ch = 0; ch < NCH; ch++) begin
            int idx;
            int q[$];
            bit hit;
            bit expd;
            idx  = m * 2 + ch;
            hit  = 0;
            expd = 0;
            q.delete();
            if (d) begin
                att[idx].delete();
            end else begin
                if (t[ch]) att[idx].push_back(0);
                foreach (att[idx][j]) begin
                    int a;
                    a = att[idx][j];
                    if (r[ch] && a >= mn && a <= MAXD) hit = 1;
                    else if (a == MAXD) expd = 1;
                    else q.push_back(a + 1);
                end
                att[idx] = q;
            end
            e_pass[m][ch] = hit;
            e_fail[m][ch] = expd;
            e_pend[m][ch] = (att[idx].size() != 0);
            if (c) begin
                e_sticky[m][ch] = 1'b0;
                e_cnt[m][ch]    = '0;
            end else if (expd) begin
                e_sticky[m][ch] = 1'b1;
                if (e_cnt[m][ch] != 4'hf) e_cnt[m][ch] = e_cnt[m][ch] + 4'd1;
            end
        end
    endtask

    task automatic check_models();
        chk("pass0",   bus0.pass_o,        e_pass[0]);
        chk("fail0",   bus0.fail_o,        e_fail[0]);
        chk("pend0",   bus0.pending_o,     e_pend[0]);
        chk("sticky0", bus0.fail_sticky_o, e_sticky[0]);
        chk("cnt0",    bus0.fail_cnt_o,    {e_cnt[0][1], e_cnt[0][0]});
        chk("excl0",   bus0.pass_o & bus0.fail_o, 0);
        chk("pass1",   bus1.pass_o,        e_pass[1]);
        chk("fail1",   bus1.fail_o,        e_fail[1]);
        chk("pend1",   bus1.pending_o,     e_pend[1]);
        chk("sticky1", bus1.fail_sticky_o, e_sticky[1]);
        chk("cnt1",    bus1.fail_cnt_o,    {e_cnt[1][1], e_cnt[1][0]});
        chk("excl1",   bus1.pass_o & bus1.fail_o, 0);
    endtask

    task automatic step(input logic [1:0] t, input logic [1:0] r, input logic d, input logic c);
        bus0.trig_i = t;
        bus0.resp_i = r;
        bus0.dis_i  = d;
        bus0.clr_i  = c;
        model_step(0, 1, t, r, d, c);
        model_step(1, 0, t, r, d, c);
        @(posedge clk);
        #1;
        check_models();
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pass"},   {bus1.pass_o, bus0.pass_o}, 0);
        chk({tag, "_fail"},   {bus1.fail_o, bus0.fail_o}, 0);
        chk({tag, "_pend"},   {bus1.pending_o, bus0.pending_o}, 0);
        chk({tag, "_sticky"}, {bus1.fail_sticky_o, bus0.fail_sticky_o}, 0);
        chk({tag, "_cnt"},    {bus1.fail_cnt_o, bus0.fail_cnt_o}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // trig, resp, dis, clr | pass, fail, pend, sticky  (MIN_DLY=1 instance)
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01});
        vecs.push_back('{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b11});
        vecs.push_back('{2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b11});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b11});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        vecs.push_back('{2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});

        // Clock/reset
        bus0.trig_i = '0;
        bus0.resp_i = '0;
        bus0.dis_i  = 1'b0;
        bus0.clr_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].trig, vecs[i].resp, vecs[i].dis, vecs[i].clr);
            chk("vec_pass",   bus0.pass_o,        vecs[i].pass);
            chk("vec_fail",   bus0.fail_o,        vecs[i].fail);
            chk("vec_pend",   bus0.pending_o,     vecs[i].pend);
            chk("vec_sticky", bus0.fail_sticky_o, vecs[i].sticky);
            if (i == 24) chk("vec_cnt_after_overlap", bus0.fail_cnt_o, 8'h12);
        end

        // MIN_DLY=0: resp in the trig cycle passes one edge later
        step(2'b10, 2'b10, 1'b0, 1'b0);
        chk("min0_pass", bus1.pass_o, 2'b10);
        chk("min0_pend", bus1.pending_o, 2'b00);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // Random traffic against the attempt-list model
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] t, r;
            t = 2'($urandom_range(0, 3));
            r[0] = ($urandom_range(0, 9) < 3);
            r[1] = ($urandom_range(0, 9) < 3);
            step(t, r, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end

        // Saturation: drain, clear, then 23 back-to-back unanswered trigs
        repeat (4) step(2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        chk("sat_cnt_start", bus0.fail_cnt_o, 8'h00);
        repeat (23) step(2'b01, 2'b00, 1'b0, 1'b0);
        chk("sat_cnt_hold", bus0.fail_cnt_o[3:0], 4'hf);
        repeat (4) step(2'b00, 2'b00, 1'b0, 1'b0);
        chk("sat_cnt_final", bus0.fail_cnt_o[3:0], 4'hf);
        chk("sat_sticky", bus0.fail_sticky_o, 2'b01);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        chk("clr_cnt", bus0.fail_cnt_o, 8'h00);
        chk("clr_sticky", bus0.fail_sticky_o, 2'b00);

        // Clear coincident with an expiry: pulse still fires, counters stay 0
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        chk("clr_exp_fail", bus0.fail_o, 2'b01);
        chk("clr_exp_cnt", bus0.fail_cnt_o, 8'h00);

        // Reset asserted mid-attempt
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(2'b00, 2'b00, 1'b0, 1'b0);
            chk("post_rst_fail", {bus1.fail_o, bus0.fail_o}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sva_window_monitor.md
Name: sva_window_monitor

Overview:
Synthesizable multi-channel checker for the bounded-response property "trig |-> ##[MIN_DLY:MAX_DLY] resp", with a "disable iff" input. It tracks overlapping attempts per channel and reports a registered pass or fail per channel. It also keeps sticky failure flags and saturating failure counters, so it can be dropped into RTL as a hardware monitor for protocol properties on handshake and response paths.

Parameters:
NCH, 4, number of independent channels (>=1)
MIN_DLY, 1, earliest response cycle after trig (>=0)
MAX_DLY, 3, latest response cycle after trig (>=MIN_DLY, >=1)
CNT_W, 8, width of each per-channel failure counter (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
dis_i  in  1  disable-iff; high kills all pending attempts on all channels
clr_i  in  1  synchronous clear of fail_sticky_o and fail_cnt_o
trig_i  in  NCH  antecedent per channel
resp_i  in  NCH  consequent per channel
pass_o  out  NCH  1-cycle pulse: at least one attempt discharged in previous cycle
fail_o  out  NCH  1-cycle pulse: at least one attempt expired in previous cycle
fail_sticky_o  out  NCH  set on any fail, held until clr_i or rst
fail_cnt_o  out  NCH*CNT_W  packed per-channel saturating fail count; channel i at [i*CNT_W +: CNT_W]
pending_o  out  NCH  registered; channel has at least one attempt in flight

Behaviour:
- Reset (rst=1, asynchronous): all outputs, pending state and counters go to 0.
- Per-channel state: pend_q[1..MAX_DLY]. Bit k set means an attempt started k cycles ago and is not yet discharged.
- Combinational live vector in each cycle:
  - live[0] = trig_i[i] & ~dis_i
  - live[k] = pend_q[k] for k = 1..MAX_DLY
- Window: ages MIN_DLY..MAX_DLY inclusive. If resp_i[i]=1, every live[k] in the window is discharged in that same cycle. One resp can satisfy several overlapping attempts, matching per-attempt SVA semantics.
- Ages below MIN_DLY are not discharged by resp. With MIN_DLY=0, resp in the trig cycle passes immediately.
- Discharge event: resp_i[i] & any live[k] in window. Registered to pass_o[i] on the next edge.
- Expiry event: live[MAX_DLY] & ~resp_i[i]. Registered to fail_o[i] on the next edge.
- pass_o and fail_o may both pulse in the same cycle only if they come from different attempts. With the rule above this cannot happen, because resp at MAX age discharges every in-window attempt. The bench asserts mutual exclusion.
- Next state: pend_q[k+1] <= live[k] & ~discharged[k] for k = 0..MAX_DLY-1. Age MAX_DLY always leaves the pipe.
- pending_o[i] <= |(next pend_q).
- dis_i=1:
  - Next pend_q is all zero on every channel.
  - Discharge and expiry events in that cycle are suppressed, so no pass/fail pulse follows.
  - A trig in that cycle is ignored.
- fail_sticky_o[i] <= 1 on an expiry event.
- fail_cnt_o[i] increments by 1 per expiry event and saturates at 2^CNT_W-1. Multiple attempts cannot expire in the same cycle on one channel, so the increment is at most 1.
- clr_i=1: sticky and counters go to 0. If an expiry happens in the same cycle, clr wins for counter and sticky; the fail_o pulse is still produced.
- Channels are fully independent. dis_i and clr_i are global.
- Latency:
  - Decision is made in the cycle resp arrives, or at the age-MAX_DLY cycle.
  - Outputs are visible one cycle later.
- Implementation: generate loop over NCH, shift-register per channel, no memories.

Test Plan:
All scenarios use NCH=2, MIN_DLY=1, MAX_DLY=3, CNT_W=4; "cycle n" means the nth edge after reset release.
1. trig[0] at cycle 0, resp[0] at cycle 2 -> pass_o[0]=1 at cycle 3 only; fail_o=0; fail_cnt ch0=0; pending_o[0] high for cycles 1-2.
2. trig[0] at cycle 0, no resp -> fail_o[0]=1 at cycle 4; fail_sticky_o[0]=1; fail_cnt ch0=1. Channel 1 stays untouched.
3. trig[1] at 0 with resp[1] at 0 only, then resp[1] at 4 -> the cycle-0 resp is ignored because it is below MIN, the cycle-4 resp is too late, and fail_o[1] pulses at 4. Repeat with MIN_DLY=0 -> pass_o[1] at cycle 1.
4. Overlap: trig[0] at 0,1,2 and resp[0] at 3 -> a single pass_o[0] pulse at 4 and no fails. Separately, trig at 0 and 2 with resp only at 2 -> pass at 3, fail_o at 6, fail_cnt=1.
5. trig[0] at 0, dis_i at 2 -> no pass/fail ever, and pending_o[0]=0 from cycle 3. A trig coincident with dis is ignored.
6. Force 20 expiries on ch0 -> fail_cnt ch0 holds at 15. Pulse clr_i -> counter 0, sticky 0. Assert rst mid-attempt -> all outputs 0 immediately, with no fail after release.
